// File: rtl/tbus_drive_ctrl_if.sv
// rtl/tbus_drive_ctrl_if.sv - write channel and shared-bus signals of tbus_drive_ctrl
interface tbus_drive_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             bus_req;
  logic             bus_gnt;
  logic [WIDTH-1:0] drv_data;
  logic             drv_ena;
  logic             sent;
  logic             busy;

  // upstream writer plus bus arbiter side
  modport master (
    output wr_valid, wr_data, bus_gnt,
    input  wr_ready, bus_req, drv_data, drv_ena, sent, busy
  );

  // drive controller side
  modport slave (
    input  wr_valid, wr_data, bus_gnt,
    output wr_ready, bus_req, drv_data, drv_ena, sent, busy
  );
endinterface

// File: rtl/tbus_drive_ctrl.sv
// rtl/tbus_drive_ctrl.sv - FIFO-buffered requester that drives words onto a shared tristate bus
module tbus_drive_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TURN  = 1
) (
  input logic               clk,
  input logic               rst_n,
  tbus_drive_ctrl_if.slave  bif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_TURN,
    S_DRIVE,
    S_RELEASE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       turn_cnt;
  logic [2:0]       turn_cnt_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Acceptance depends only on the registered count; a pop in the same cycle gives no credit.
  assign bif.wr_ready = (count < CW'(DEPTH));
  assign push         = bif.wr_valid && bif.wr_ready;
  // Each DRIVE cycle consumes the head word; DRIVE is only entered with a non-empty FIFO.
  assign pop          = (state == S_DRIVE);

  // FIFO storage; contents need no reset because reads are gated by state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bif.wr_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State and turnaround counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
    end
  end

  // Bus acquisition, turnaround, burst and release sequencing.
  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bif.bus_gnt) begin
          if (TURN == 0) begin
            state_nxt = S_DRIVE;
          end else begin
            state_nxt    = S_TURN;
            turn_cnt_nxt = 3'(TURN);
          end
        end
      end
      S_TURN: begin
        if (!bif.bus_gnt) begin
          state_nxt = S_REQ;
        end else if (turn_cnt == 3'd1) begin
          state_nxt = S_DRIVE;
        end else begin
          turn_cnt_nxt = turn_cnt - 3'd1;
        end
      end
      S_DRIVE: begin
        // Grant loss is honoured at the word boundary; the current word still completes.
        if ((count > CW'(1)) && bif.bus_gnt) begin
          state_nxt = S_DRIVE;
        end else begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs come from registered state and the FIFO head only, so reset clears them at once.
  assign bif.bus_req  = (state == S_REQ) || (state == S_TURN) || (state == S_DRIVE);
  assign bif.drv_ena  = (state == S_DRIVE);
  assign bif.sent     = (state == S_DRIVE);
  assign bif.drv_data = (state == S_DRIVE) ? mem[rd_ptr] : '0;
  assign bif.busy     = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_tbus_drive_ctrl.sv
// tb/tb_tbus_drive_ctrl.sv - self-checking bench for tbus_drive_ctrl
module tb_tbus_drive_ctrl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 4;
  localparam int TURN_A = 1;
  localparam int TURN_B = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tbus_drive_ctrl_if #(.WIDTH(WIDTH)) bif_a ();
  tbus_drive_ctrl_if #(.WIDTH(WIDTH)) bif_b ();

  tbus_drive_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TURN(TURN_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif_a)
  );

  tbus_drive_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TURN(TURN_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model for dut_a: word queue plus bus-ownership bookkeeping
  logic [WIDTH-1:0] q [$];
  bit               m_req;
  bit               m_drive;
  bit               m_rel;
  int               m_run;
  logic [WIDTH-1:0] log_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_req   = 1'b0;
    m_drive = 1'b0;
    m_rel   = 1'b0;
    m_run   = 0;
  endtask

  // advance the model across one clock edge using the inputs presented for that edge
  task automatic model_edge();
    int sz;
    bit pop;
    bit push;
    sz   = q.size();
    pop  = m_drive;
    push = bif_a.wr_valid && (sz < DEPTH);
    if (m_drive) begin
      m_drive = (sz > 1) && bif_a.bus_gnt;
      if (!m_drive) begin
        m_rel = 1'b1;
        m_req = 1'b0;
      end
    end else if (m_rel) begin
      m_rel = 1'b0;
    end else if (!m_req) begin
      if (sz != 0) begin
        m_req = 1'b1;
        m_run = 0;
      end
    end else if (bif_a.bus_gnt) begin
      m_run++;
      if (m_run == TURN_A + 1) m_drive = 1'b1;
    end else begin
      m_run = 0;
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(bif_a.wr_data);
  endtask

  task automatic check_outputs();
    logic [WIDTH-1:0] exp_data;
    exp_data = (m_drive && q.size() != 0) ? q[0] : '0;
    check("mdl_ready", bif_a.wr_ready, q.size() < DEPTH);
    check("mdl_req",   bif_a.bus_req,  m_req || m_drive);
    check("mdl_ena",   bif_a.drv_ena,  m_drive);
    check("mdl_sent",  bif_a.sent,     m_drive);
    check("mdl_data",  bif_a.drv_data, exp_data);
    check("mdl_busy",  bif_a.busy,     m_req || m_drive || m_rel || (q.size() != 0));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    bif_a.wr_valid = 1'b0;
    bif_a.wr_data  = '0;
    bif_a.bus_gnt  = 1'b0;
    bif_b.wr_valid = 1'b0;
    bif_b.wr_data  = '0;
    bif_b.bus_gnt  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_outputs();
    check("rst_b_req", bif_b.bus_req, 0);
    check("rst_b_ena", bif_b.drv_ena, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] t1_req;
    logic [5:0] t1_ena;
    logic [5:0] t1_busy;
    logic [9:0] tb_gnt;
    logic [9:0] tb_req;
    logic [9:0] tb_ena;
    int         n_sent;
    int         drop;
    int         c2;
    int         c3;
    int         gaps;
    bit         started;
    bit         pushed;
    logic [WIDTH-1:0] next_data;

    idle_inputs();

    // 1: single word, grant tied high
    do_reset();
    t1_req  = 6'b001110;
    t1_ena  = 6'b001000;
    t1_busy = 6'b011111;
    bif_a.bus_gnt  = 1'b1;
    bif_a.wr_valid = 1'b1;
    bif_a.wr_data  = 8'hA5;
    for (int c = 0; c < 6; c++) begin
      tick();
      bif_a.wr_valid = 1'b0;
      check("t1_req",  bif_a.bus_req,  t1_req[c]);
      check("t1_ena",  bif_a.drv_ena,  t1_ena[c]);
      check("t1_sent", bif_a.sent,     t1_ena[c]);
      check("t1_busy", bif_a.busy,     t1_busy[c]);
      check("t1_data", bif_a.drv_data, (c == 3) ? 8'hA5 : 8'h00);
    end

    // 2: fill the FIFO while the grant is held off, then burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bif_a.wr_valid = 1'b1;
      bif_a.wr_data  = 8'(i + 1);
      tick();
    end
    bif_a.wr_valid = 1'b0;
    check("t2_full", bif_a.wr_ready, 0);
    tick();
    bif_a.bus_gnt = 1'b1;
    log_q.delete();
    c2 = -1;
    c3 = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bif_a.sent) begin
        log_q.push_back(bif_a.drv_data);
        if (log_q.size() == 1) c2 = c;
        if (log_q.size() == 4) c3 = c;
      end
    end
    check("t2_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t2_order", log_q[i], i + 1);
    check("t2_b2b", c3 - c2, 3);
    check("t2_idle", bif_a.busy, 0);

    // 3: grant dropped during the second drive cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bif_a.wr_valid = 1'b1;
      bif_a.wr_data  = 8'(i + 1);
      tick();
    end
    bif_a.wr_valid = 1'b0;
    bif_a.bus_gnt  = 1'b1;
    log_q.delete();
    n_sent = 0;
    drop   = 0;
    c2     = 0;
    c3     = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bif_a.sent) begin
        log_q.push_back(bif_a.drv_data);
        n_sent++;
        if (n_sent == 2) begin
          drop = 3;
          c2   = c;
        end
        if (n_sent == 3) c3 = c;
      end
      bif_a.bus_gnt = (drop == 0);
      if (drop > 0) drop--;
    end
    check("t3_count", log_q.size(), 4);
    for (int i = 0; i < 4 && i < log_q.size(); i++) check("t3_order", log_q[i], i + 1);
    check("t3_split", (c3 - c2) > 4, 1);

    // 4: grant withdrawn during turnaround on the TURN=3 instance
    do_reset();
    tb_gnt = 10'b0111101100;
    tb_req = 10'b0111111110;
    tb_ena = 10'b0100000000;
    bif_b.wr_data = 8'h3C;
    for (int e = 0; e < 10; e++) begin
      bif_b.bus_gnt  = tb_gnt[e];
      bif_b.wr_valid = (e == 0);
      @(posedge clk);
      #1;
      check("t4_req",  bif_b.bus_req,  tb_req[e]);
      check("t4_ena",  bif_b.drv_ena,  tb_ena[e]);
      check("t4_data", bif_b.drv_data, (e == 8) ? 8'h3C : 8'h00);
    end
    bif_b.wr_valid = 1'b0;
    bif_b.bus_gnt  = 1'b0;

    // 5: asynchronous reset in the middle of a burst
    do_reset();
    bif_a.bus_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif_a.wr_valid = 1'b1;
      bif_a.wr_data  = 8'(8'h10 + i);
      tick();
    end
    bif_a.wr_valid = 1'b0;
    for (int c = 0; c < 10 && !m_drive; c++) tick();
    check("t5_in_drive", bif_a.drv_ena, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_ena", bif_a.drv_ena, 0);
    check("t5_req", bif_a.bus_req, 0);
    check("t5_sent", bif_a.sent, 0);
    check("t5_data", bif_a.drv_data, 0);
    #2;
    rst_n = 1'b1;
    model_clear();
    bif_a.bus_gnt = 1'b0;
    tick();
    check("t5_busy", bif_a.busy, 0);
    check("t5_ready", bif_a.wr_ready, 1);
    tick();

    // 6: continuous push and pop, 64 words
    do_reset();
    bif_a.bus_gnt = 1'b1;
    next_data     = 8'h00;
    log_q.delete();
    gaps    = 0;
    started = 1'b0;
    for (int c = 0; c < 300 && log_q.size() < 64; c++) begin
      bif_a.wr_valid = (next_data < 8'd64);
      bif_a.wr_data  = next_data;
      pushed = bif_a.wr_valid && (q.size() < DEPTH);
      tick();
      if (pushed) next_data++;
      if (bif_a.sent) begin
        started = 1'b1;
        log_q.push_back(bif_a.drv_data);
      end else if (started) begin
        gaps++;
      end
    end
    bif_a.wr_valid = 1'b0;
    check("t6_count", log_q.size(), 64);
    check("t6_gaps", gaps, 0);
    for (int i = 0; i < log_q.size(); i++) check("t6_order", log_q[i], i);
    tick();
    check("t6_done", bif_a.busy, 1);
    tick();
    check("t6_idle", bif_a.busy, 0);

    // random traffic and grant against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bif_a.wr_valid = ($urandom_range(0, 2) != 0);
      bif_a.wr_data  = 8'($urandom);
      bif_a.bus_gnt  = ($urandom_range(0, 9) < 7);
      tick();
    end
    bif_a.wr_valid = 1'b0;
    bif_a.bus_gnt  = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    check("rnd_drain", bif_a.busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
